reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Register-result scoreboard sitting beside the register file: tracks, per GPR, how many issued
//  instructions still owe a write-back, and stalls issue when a source is still pending.
//  Issue side (D stage) marks destinations pending; write-back side (W stage) retires them.
//  Drives the pipeline stall and gives the reader side of the register file a readiness view.
// PARAMETERS
//  NREG   32  number of architectural registers (register 0 never tracked)
//  AW     5   register address width, clog2(NREG)
//  CNT_W  2   per-register in-flight counter width; max in-flight per register = 2**CNT_W-1
//  TOT_W  7   width of pending_total; must hold (NREG-1)*(2**CNT_W-1)
// PORTS
//  clk            in   1      clock, all state updates on posedge
//  reset          in   1      synchronous, active-high
//  flush          in   1      discard all in-flight tracking (pipeline flush)
//  issue_valid    in   1      D stage presents an instruction
//  issue_ready    out  1      scoreboard accepts it this cycle
//  issue_use1     in   1      instruction reads issue_ra1
//  issue_ra1      in   AW     source register 1
//  issue_use2     in   1      instruction reads issue_ra2
//  issue_ra2      in   AW     source register 2
//  issue_we       in   1      instruction writes issue_wa
//  issue_wa       in   AW     destination register
//  wb_we          in   1      W stage commits a register write this cycle
//  wb_wa          in   AW     register being written
//  busy1          out  1      issue_ra1 has outstanding writes (after same-cycle bypass)
//  busy2          out  1      issue_ra2 has outstanding writes (after same-cycle bypass)
//  stall          out  1      hazard: (use1&busy1)|(use2&busy2)|dest counter saturated
//  pending_total  out  TOT_W  registered sum of all counters
//  err_underflow  out  1      sticky: write-back retired a register whose counter was 0
// BEHAVIOUR
//  - Reset (sync, priority over all): every counter 0, pending_total 0, err_underflow 0.
//  - cnt[0] is constant 0; issue_wa==0 or wb_wa==0 never changes any state; ra==0 never busy.
//  - Effective count eff[r] = cnt[r] - (wb_we && wb_wa==r && cnt[r]!=0): write-back in the same
//    cycle counts as done (data forwarded from W), so busyN = (raN!=0) && eff[raN]!=0.
//  - sat = issue_we && issue_wa!=0 && cnt[issue_wa]==2**CNT_W-1 && !(wb hit on issue_wa).
//  - stall combinational: (issue_use1&busy1)|(issue_use2&busy2)|sat. issue_ready = !stall.
//  - Accept = issue_valid && issue_ready && !flush. On accept with issue_we, cnt[issue_wa]+1.
//  - wb_we: cnt[wb_wa]-1 if nonzero; if zero, counter stays 0 and err_underflow sets (sticky
//    until reset; flush does not clear it).
//  - Same register incremented by accept and decremented by wb in one cycle: count unchanged.
//  - flush (no reset): all counters 0 and pending_total 0 next edge; issue/wb that cycle ignored.
//  - Outputs busy/stall/issue_ready have zero latency from inputs; counters update at posedge.
//  - pending_total tracks sum: +1 accept-with-write, -1 valid retire, net 0 when both.
//  - No state machine; all state is the counter array, pending_total and the sticky flag.
// STRUCTURE
//  - Shared package sb_pkg: NREG, AW, CNT_W, TOT_W constants; cnt_t typedef (CNT_W bits).
//  - Sub-module sb_counter: one saturating up/down counter with inc, dec, clr, sync reset,
//    outputs count, zero, full; instantiated by generate for registers 1..NREG-1.
//  - Top: hit decode for issue/wb addresses, bypass muxing for busy, stall logic, total adder.
// TESTING
//  1 reset asserted 2 cycles mid-traffic -> all busy 0, pending_total 0, err_underflow 0.
//  2 issue wa=5 we=1; next cycle ra1=5 use1=1 -> stall=1, busy1=1; no wb -> stall holds.
//  3 cnt[5]=1, wb_wa=5 with ra1=5 same cycle -> busy1=0, stall=0; next cycle cnt[5]=0.
//  4 issue wa=7 three times (no wb) -> pending_total=3; 4th issue wa=7 -> issue_ready=0,
//    count stays 3; same-cycle wb_wa=7 -> accepted, count 3.
//  5 issue wa=0 and ra1=0 use1=1 -> never stall, pending_total unchanged; wb wa=0 -> no error.
//  6 pending on r3,r9, flush=1 with issue wa=4 -> next cycle all 0, r4 not tracked;
//    then wb_wa=3 -> err_underflow=1 and stays 1 until reset.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared constants and types for the register-result scoreboard.
// Geometry must satisfy TOT_W holding (NREG-1)*CNT_MAX.
package sb_pkg;
    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 2;
    localparam int TOT_W = 7;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [AW-1:0]    addr_t;
    typedef logic [TOT_W-1:0] tot_t;

    localparam cnt_t CNT_MAX = '1;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/write-back/status bundle between the pipeline and the scoreboard.
// The pipeline is the master; the scoreboard is the slave.
interface reg_scoreboard_if;
    import sb_pkg::*;

    logic  flush;
    logic  issue_valid;
    logic  issue_ready;
    logic  issue_use1;
    addr_t issue_ra1;
    logic  issue_use2;
    addr_t issue_ra2;
    logic  issue_we;
    addr_t issue_wa;
    logic  wb_we;
    addr_t wb_wa;
    logic  busy1;
    logic  busy2;
    logic  stall;
    tot_t  pending_total;
    logic  err_underflow;

    modport master (
        output flush, issue_valid, issue_use1, issue_ra1, issue_use2, issue_ra2,
               issue_we, issue_wa, wb_we, wb_wa,
        input  issue_ready, busy1, busy2, stall, pending_total, err_underflow
    );

    modport slave (
        input  flush, issue_valid, issue_use1, issue_ra1, issue_use2, issue_ra2,
               issue_we, issue_wa, wb_we, wb_wa,
        output issue_ready, busy1, busy2, stall, pending_total, err_underflow
    );
endinterface

// File: rtl/sb_counter.sv
// Saturating up/down in-flight counter for one register.
// Simultaneous inc and dec cancel; clear wins over both.
module sb_counter
    import sb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    input  logic i_dec,
    output cnt_t o_count,
    output logic o_zero,
    output logic o_full
);
    cnt_t r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && !o_full) begin
            r_count <= r_count + cnt_t'(1);
        end else if (i_dec && !i_inc && !o_zero) begin
            r_count <= r_count - cnt_t'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);
    assign o_full  = (r_count == CNT_MAX);
endmodule

// File: rtl/reg_scoreboard.sv
// Register-result scoreboard: per-GPR in-flight write counts, issue stall
// with same-cycle write-back bypass, running pending total and sticky underflow.
module reg_scoreboard
    import sb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    reg_scoreboard_if.slave sb_if
);
    cnt_t [NREG-1:0] w_cnt;
    logic [NREG-1:0] w_zero;
    logic [NREG-1:0] w_full;
    logic [NREG-1:1] w_inc;
    logic [NREG-1:1] w_dec;
    logic            w_inc_any;
    logic            w_dec_any;
    logic            w_sat;
    logic            w_stall;
    logic            w_accept;
    logic            w_underflow;
    logic            w_wb_hit1;
    logic            w_wb_hit2;
    logic            w_wb_hit_dst;
    tot_t            r_total;
    logic            r_err;

    // Register 0 is hardwired: never pending, never full.
    assign w_cnt[0]  = '0;
    assign w_zero[0] = 1'b1;
    assign w_full[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter u_cnt (
            .clk     (clk),
            .reset   (reset),
            .i_clr   (sb_if.flush),
            .i_inc   (w_inc[r]),
            .i_dec   (w_dec[r]),
            .o_count (w_cnt[r]),
            .o_zero  (w_zero[r]),
            .o_full  (w_full[r])
        );
    end

    // A write-back landing this cycle is forwarded, so a count of 1 being retired is not busy.
    assign w_wb_hit1    = sb_if.wb_we && (sb_if.wb_wa == sb_if.issue_ra1);
    assign w_wb_hit2    = sb_if.wb_we && (sb_if.wb_wa == sb_if.issue_ra2);
    assign w_wb_hit_dst = sb_if.wb_we && (sb_if.wb_wa == sb_if.issue_wa);

    assign sb_if.busy1 = (sb_if.issue_ra1 != '0) && !w_zero[sb_if.issue_ra1]
                         && !(w_wb_hit1 && (w_cnt[sb_if.issue_ra1] == cnt_t'(1)));
    assign sb_if.busy2 = (sb_if.issue_ra2 != '0) && !w_zero[sb_if.issue_ra2]
                         && !(w_wb_hit2 && (w_cnt[sb_if.issue_ra2] == cnt_t'(1)));

    assign w_sat   = sb_if.issue_we && (sb_if.issue_wa != '0)
                     && w_full[sb_if.issue_wa] && !w_wb_hit_dst;
    assign w_stall = (sb_if.issue_use1 && sb_if.busy1)
                     || (sb_if.issue_use2 && sb_if.busy2) || w_sat;

    assign sb_if.stall       = w_stall;
    assign sb_if.issue_ready = !w_stall;
    assign w_accept          = sb_if.issue_valid && !w_stall && !sb_if.flush;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int r = 1; r < NREG; r++) begin
            w_inc[r] = w_accept && sb_if.issue_we && (sb_if.issue_wa == addr_t'(r));
            w_dec[r] = !sb_if.flush && sb_if.wb_we && (sb_if.wb_wa == addr_t'(r)) && !w_zero[r];
        end
    end

    assign w_inc_any   = |w_inc;
    assign w_dec_any   = |w_dec;
    assign w_underflow = !sb_if.flush && sb_if.wb_we && (sb_if.wb_wa != '0)
                         && w_zero[sb_if.wb_wa];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_total <= '0;
            r_err   <= 1'b0;
        end else begin
            if (sb_if.flush) begin
                r_total <= '0;
            end else begin
                r_total <= r_total + tot_t'(w_inc_any) - tot_t'(w_dec_any);
            end
            if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    assign sb_if.pending_total = r_total;
    assign sb_if.err_underflow = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;
    import sb_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    reg_scoreboard_if sb_if ();

    reg_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .sb_if (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.flush       = 1'b0;
        sb_if.issue_valid = 1'b0;
        sb_if.issue_use1  = 1'b0;
        sb_if.issue_ra1   = '0;
        sb_if.issue_use2  = 1'b0;
        sb_if.issue_ra2   = '0;
        sb_if.issue_we    = 1'b0;
        sb_if.issue_wa    = '0;
        sb_if.wb_we       = 1'b0;
        sb_if.wb_wa       = '0;
    endtask

    task automatic issue_write(input addr_t wa);
        idle();
        sb_if.issue_valid = 1'b1;
        sb_if.issue_we    = 1'b1;
        sb_if.issue_wa    = wa;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (sb_if.pending_total !== 7'd0 || sb_if.err_underflow !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_init: total=%0d err=%b required total=0 err=0",
                     sb_if.pending_total, sb_if.err_underflow);
        end
        // Build some traffic plus an underflow, then reset mid-traffic.
        issue_write(5'd5);
        tick();
        issue_write(5'd6);
        sb_if.wb_we = 1'b1;
        sb_if.wb_wa = 5'd9;
        tick();
        idle();
        #1;
        n_checks++;
        if (sb_if.pending_total !== 7'd2 || sb_if.err_underflow !== 1'b1) begin
            n_fails++;
            $display("FAIL pre_reset_traffic: total=%0d err=%b required total=2 err=1",
                     sb_if.pending_total, sb_if.err_underflow);
        end
        issue_write(5'd8);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        idle();
        sb_if.issue_use1 = 1'b1;
        sb_if.issue_ra1  = 5'd5;
        sb_if.issue_use2 = 1'b1;
        sb_if.issue_ra2  = 5'd6;
        #1;
        n_checks++;
        if (sb_if.pending_total !== 7'd0 || sb_if.err_underflow !== 1'b0
            || sb_if.busy1 !== 1'b0 || sb_if.busy2 !== 1'b0 || sb_if.stall !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_mid_traffic: total=%0d err=%b busy1=%b busy2=%b stall=%b required all 0",
                     sb_if.pending_total, sb_if.err_underflow, sb_if.busy1, sb_if.busy2, sb_if.stall);
        end
        idle();
    endtask

    task automatic test_raw_stall();
        issue_write(5'd5);
        tick();
        idle();
        sb_if.issue_valid = 1'b1;
        sb_if.issue_use1  = 1'b1;
        sb_if.issue_ra1   = 5'd5;
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b1 || sb_if.busy1 !== 1'b1 || sb_if.issue_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL raw_stall: stall=%b busy1=%b ready=%b required 1 1 0",
                     sb_if.stall, sb_if.busy1, sb_if.issue_ready);
        end
        tick();
        n_checks++;
        if (sb_if.stall !== 1'b1 || sb_if.pending_total !== 7'd1) begin
            n_fails++;
            $display("FAIL raw_stall_hold: stall=%b total=%0d required stall=1 total=1",
                     sb_if.stall, sb_if.pending_total);
        end
        // Same register on ra2 but unused must not stall.
        sb_if.issue_use1 = 1'b0;
        sb_if.issue_ra1  = '0;
        sb_if.issue_ra2  = 5'd5;
        #1;
        n_checks++;
        if (sb_if.busy2 !== 1'b1 || sb_if.stall !== 1'b0) begin
            n_fails++;
            $display("FAIL unused_src2: busy2=%b stall=%b required busy2=1 stall=0",
                     sb_if.busy2, sb_if.stall);
        end
        sb_if.issue_valid = 1'b0;
    endtask

    task automatic test_bypass();
        idle();
        sb_if.issue_valid = 1'b1;
        sb_if.issue_use1  = 1'b1;
        sb_if.issue_ra1   = 5'd5;
        sb_if.wb_we       = 1'b1;
        sb_if.wb_wa       = 5'd5;
        #1;
        n_checks++;
        if (sb_if.busy1 !== 1'b0 || sb_if.stall !== 1'b0 || sb_if.issue_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL wb_bypass: busy1=%b stall=%b ready=%b required 0 0 1",
                     sb_if.busy1, sb_if.stall, sb_if.issue_ready);
        end
        tick();
        sb_if.wb_we = 1'b0;
        #1;
        n_checks++;
        if (sb_if.busy1 !== 1'b0 || sb_if.pending_total !== 7'd0 || sb_if.err_underflow !== 1'b0) begin
            n_fails++;
            $display("FAIL after_retire: busy1=%b total=%0d err=%b required 0 0 0",
                     sb_if.busy1, sb_if.pending_total, sb_if.err_underflow);
        end
        idle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            issue_write(5'd7);
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (sb_if.pending_total !== 7'd3) begin
            n_fails++;
            $display("FAIL sat_fill: total=%0d required 3", sb_if.pending_total);
        end
        issue_write(5'd7);
        #1;
        n_checks++;
        if (sb_if.issue_ready !== 1'b0 || sb_if.stall !== 1'b1) begin
            n_fails++;
            $display("FAIL sat_block: ready=%b stall=%b required ready=0 stall=1",
                     sb_if.issue_ready, sb_if.stall);
        end
        tick();
        n_checks++;
        if (sb_if.pending_total !== 7'd3) begin
            n_fails++;
            $display("FAIL sat_no_inc: total=%0d required 3", sb_if.pending_total);
        end
        sb_if.wb_we = 1'b1;
        sb_if.wb_wa = 5'd7;
        #1;
        n_checks++;
        if (sb_if.issue_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL sat_with_wb: ready=%b required 1", sb_if.issue_ready);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (sb_if.pending_total !== 7'd3) begin
            n_fails++;
            $display("FAIL sat_inc_dec: total=%0d required 3", sb_if.pending_total);
        end
        // Drain r7 completely; counts must step 2,1,0 without underflow.
        for (int i = 0; i < 3; i++) begin
            idle();
            sb_if.wb_we = 1'b1;
            sb_if.wb_wa = 5'd7;
            tick();
        end
        idle();
        sb_if.issue_use1 = 1'b1;
        sb_if.issue_ra1  = 5'd7;
        #1;
        n_checks++;
        if (sb_if.pending_total !== 7'd0 || sb_if.busy1 !== 1'b0 || sb_if.err_underflow !== 1'b0) begin
            n_fails++;
            $display("FAIL sat_drain: total=%0d busy1=%b err=%b required 0 0 0",
                     sb_if.pending_total, sb_if.busy1, sb_if.err_underflow);
        end
        idle();
    endtask

    task automatic test_reg0();
        issue_write(5'd0);
        sb_if.issue_use1 = 1'b1;
        sb_if.issue_ra1  = 5'd0;
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b0 || sb_if.busy1 !== 1'b0) begin
            n_fails++;
            $display("FAIL reg0_stall: stall=%b busy1=%b required 0 0", sb_if.stall, sb_if.busy1);
        end
        tick();
        tick();
        n_checks++;
        if (sb_if.pending_total !== 7'd0 || sb_if.stall !== 1'b0) begin
            n_fails++;
            $display("FAIL reg0_total: total=%0d stall=%b required 0 0",
                     sb_if.pending_total, sb_if.stall);
        end
        idle();
        sb_if.wb_we = 1'b1;
        sb_if.wb_wa = 5'd0;
        tick();
        idle();
        #1;
        n_checks++;
        if (sb_if.err_underflow !== 1'b0 || sb_if.pending_total !== 7'd0) begin
            n_fails++;
            $display("FAIL reg0_wb: err=%b total=%0d required 0 0",
                     sb_if.err_underflow, sb_if.pending_total);
        end
    endtask

    task automatic test_flush_underflow();
        issue_write(5'd3);
        tick();
        issue_write(5'd9);
        tick();
        idle();
        #1;
        n_checks++;
        if (sb_if.pending_total !== 7'd2) begin
            n_fails++;
            $display("FAIL flush_pre: total=%0d required 2", sb_if.pending_total);
        end
        issue_write(5'd4);
        sb_if.flush = 1'b1;
        sb_if.wb_we = 1'b1;
        sb_if.wb_wa = 5'd12;
        tick();
        idle();
        sb_if.issue_use1 = 1'b1;
        sb_if.issue_ra1  = 5'd3;
        sb_if.issue_use2 = 1'b1;
        sb_if.issue_ra2  = 5'd9;
        #1;
        n_checks++;
        if (sb_if.pending_total !== 7'd0 || sb_if.busy1 !== 1'b0 || sb_if.busy2 !== 1'b0
            || sb_if.err_underflow !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_clear: total=%0d busy1=%b busy2=%b err=%b required 0 0 0 0",
                     sb_if.pending_total, sb_if.busy1, sb_if.busy2, sb_if.err_underflow);
        end
        sb_if.issue_ra1 = 5'd4;
        #1;
        n_checks++;
        if (sb_if.busy1 !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_r4: busy1=%b required 0", sb_if.busy1);
        end
        idle();
        sb_if.wb_we = 1'b1;
        sb_if.wb_wa = 5'd3;
        tick();
        idle();
        #1;
        n_checks++;
        if (sb_if.err_underflow !== 1'b1 || sb_if.pending_total !== 7'd0) begin
            n_fails++;
            $display("FAIL underflow_set: err=%b total=%0d required err=1 total=0",
                     sb_if.err_underflow, sb_if.pending_total);
        end
        sb_if.flush = 1'b1;
        tick();
        idle();
        tick();
        n_checks++;
        if (sb_if.err_underflow !== 1'b1) begin
            n_fails++;
            $display("FAIL underflow_sticky: err=%b required 1", sb_if.err_underflow);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (sb_if.err_underflow !== 1'b0) begin
            n_fails++;
            $display("FAIL underflow_reset: err=%b required 0", sb_if.err_underflow);
        end
    endtask

    task automatic test_back_to_back();
        issue_write(5'd10);
        tick();
        // Dependent issue on r10 while its single pending write retires: forwarded, no stall.
        issue_write(5'd10);
        sb_if.issue_use2 = 1'b1;
        sb_if.issue_ra2  = 5'd10;
        sb_if.wb_we      = 1'b1;
        sb_if.wb_wa      = 5'd10;
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b0 || sb_if.busy2 !== 1'b0 || sb_if.pending_total !== 7'd1) begin
            n_fails++;
            $display("FAIL b2b_fwd: stall=%b busy2=%b total=%0d required 0 0 1",
                     sb_if.stall, sb_if.busy2, sb_if.pending_total);
        end
        tick();
        idle();
        sb_if.issue_use2 = 1'b1;
        sb_if.issue_ra2  = 5'd10;
        #1;
        n_checks++;
        if (sb_if.pending_total !== 7'd1 || sb_if.busy2 !== 1'b1) begin
            n_fails++;
            $display("FAIL b2b_mid: total=%0d busy2=%b required total=1 busy2=1",
                     sb_if.pending_total, sb_if.busy2);
        end
        // Issue to r11 and retire r10 in the same cycle: different registers, net 0.
        issue_write(5'd11);
        sb_if.wb_we = 1'b1;
        sb_if.wb_wa = 5'd10;
        tick();
        idle();
        sb_if.issue_use1 = 1'b1;
        sb_if.issue_ra1  = 5'd11;
        sb_if.issue_use2 = 1'b1;
        sb_if.issue_ra2  = 5'd10;
        #1;
        n_checks++;
        if (sb_if.pending_total !== 7'd1 || sb_if.busy1 !== 1'b1 || sb_if.busy2 !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_mixed: total=%0d busy1=%b busy2=%b required 1 1 0",
                     sb_if.pending_total, sb_if.busy1, sb_if.busy2);
        end
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        idle();
        test_reset();
        test_raw_stall();
        test_bypass();
        test_saturation();
        test_reg0();
        test_flush_underflow();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
